// File: rtl/axis_frame_packer.sv
// rtl/axis_frame_packer.sv - packs result words into AXI4-Stream packets with length/flush/timeout framing
module axis_frame_packer #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int TO_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [TO_WIDTH-1:0]   cfg_timeout,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [31:0]           pkt_count,
  output logic                  busy
);

  // Pending stage: holds the newest word until we know whether it ends the packet.
  logic                  p_valid;
  logic                  p_last;
  logic [DATA_WIDTH-1:0] p_data;

  // Framing state: words already taken in this packet, and the length latched on its first word.
  logic [LEN_WIDTH-1:0]  cnt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [TO_WIDTH-1:0]   idle_cnt;

  logic                  o_load_ok;
  logic                  accept;
  logic                  xfer;
  logic [LEN_WIDTH-1:0]  len_eff;
  logic [LEN_WIDTH-1:0]  cnt_inc;
  logic                  in_last;
  logic                  idle_inc;
  logic                  timeout_hit;
  logic                  close_pending;

  // Handshake, framing decisions and late-close requests for the pending word.
  always_comb begin
    o_load_ok     = !m_axis_tvalid || m_axis_tready;
    in_ready      = !rst && (!p_valid || o_load_ok);
    accept        = in_valid && in_ready;
    // A non-last pending word may only leave once its successor arrives,
    // otherwise the tlast decision for it would be lost.
    xfer          = p_valid && o_load_ok && (p_last || accept);
    // The first word of a packet uses the live config; later words use the latched copy.
    len_eff       = (cnt == '0) ? cfg_frame_len : len_q;
    cnt_inc       = cnt + LEN_WIDTH'(1);
    in_last       = flush || ((len_eff != '0) && (cnt_inc == len_eff));
    idle_inc      = p_valid && !p_last && !accept;
    timeout_hit   = idle_inc && (cfg_timeout != '0) &&
                    ((idle_cnt + TO_WIDTH'(1)) == cfg_timeout);
    // Flush/timeout with no new word closes the packet on the word already held;
    // with nothing held, or the held word already last, there is nothing to close.
    close_pending = !accept && p_valid && !p_last && (flush || timeout_hit);
    busy          = p_valid || m_axis_tvalid;
  end

  // Pending stage: refill on accept, drain on transfer, mark last on a late close.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      p_data  <= '0;
    end else if (accept) begin
      p_valid <= 1'b1;
      p_last  <= in_last;
      p_data  <= in_data;
    end else if (xfer) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (close_pending) begin
      p_last  <= 1'b1;
    end
  end

  // Word counter and per-packet length latch; both restart after any last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      len_q <= '0;
    end else if (accept) begin
      if (cnt == '0) begin
        len_q <= cfg_frame_len;
      end
      cnt <= in_last ? '0 : cnt_inc;
    end else if (close_pending) begin
      cnt <= '0;
    end
  end

  // Idle timer: runs only while an open (non-last) word is waiting for a successor.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (idle_inc) begin
      idle_cnt <= idle_cnt + TO_WIDTH'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

  // Output register: loads from the pending stage, holds steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (xfer) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= p_last;
      m_axis_tdata  <= p_data;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Completed-packet counter, bumped on each tlast handshake; free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_frame_packer.sv
// tb/tb_axis_frame_packer.sv - scoreboard bench for axis_frame_packer
module tb_axis_frame_packer;
  localparam int DW = 64;
  localparam int LW = 16;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cfg_frame_len;
  logic [TW-1:0] cfg_timeout;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [31:0]   pkt_count;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    exp_pkts = 0;
  int    tready_mode = 0;
  int    last_accept_cyc = 0;
  int    flush_cyc = 0;
  beat_t sb[$];
  int    beat_cyc[$];
  int    last_cyc[$];
  beat_t mon_b;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  axis_frame_packer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TO_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .cfg_frame_len(cfg_frame_len), .cfg_timeout(cfg_timeout),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .pkt_count(pkt_count), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    sb.push_back(b);
    if (l) exp_pkts++;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic fl);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    flush    = fl;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    last_accept_cyc = cyc - 1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(n < 1000), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Sink ready pattern: 0 = always ready, 1 = held low, 2 = toggling.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        1:       m_axis_tready = 1'b0;
        2:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  // Output monitor: stall stability, then scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (stall_q) begin
      check("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
      check("hold_tdata", m_axis_tdata, stall_data);
      check("hold_tlast", 64'(m_axis_tlast), 64'(stall_last));
    end
    if (m_axis_tvalid && m_axis_tready) begin
      check("beat_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_b = sb.pop_front();
        check("beat_tdata", m_axis_tdata, mon_b.data);
        check("beat_tlast", 64'(m_axis_tlast), 64'(mon_b.last));
      end
      beat_cyc.push_back(cyc);
      if (m_axis_tlast) last_cyc.push_back(cyc);
    end
    stall_q    = m_axis_tvalid && !m_axis_tready && !rst;
    stall_data = m_axis_tdata;
    stall_last = m_axis_tlast;
  end

  initial begin
    rst = 1'b1;
    cfg_frame_len = 16'd4;
    cfg_timeout = 16'd0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fixed length 4, back-to-back, no bubbles across the boundary.
    beat_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      expect_beat(64'(i), (i % 4) == 3);
      send(64'(i), 1'b0);
    end
    drain();
    check("t1_pkts", 64'(pkt_count), 64'd2);
    check("t1_beats", 64'(beat_cyc.size()), 64'd8);
    if (beat_cyc.size() == 8) check("t1_no_bubble", 64'(beat_cyc[7] - beat_cyc[0]), 64'd7);

    // Unlimited length closed by an explicit flush.
    cfg_frame_len = 16'd0;
    last_cyc.delete();
    for (int i = 1; i <= 5; i++) begin
      expect_beat(64'(100 + i), i == 5);
      send(64'(100 + i), 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    flush_cyc = cyc;
    @(posedge clk);
    #1;
    flush = 1'b0;
    drain();
    check("t2_last_seen", 64'(last_cyc.size()), 64'd1);
    if (last_cyc.size() > 0) check("t2_flush_latency", 64'(last_cyc[0] - flush_cyc), 64'd2);
    check("t2_pkts", 64'(pkt_count), 64'(exp_pkts));

    // Idle timeout closes a short packet, then a full 16-word packet.
    cfg_frame_len = 16'd16;
    cfg_timeout = 16'd10;
    last_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      expect_beat(64'(200 + i), i == 2);
      send(64'(200 + i), 1'b0);
    end
    drain();
    check("t3_last_seen", 64'(last_cyc.size()), 64'd1);
    if (last_cyc.size() > 0) check("t3_timeout_cycle", 64'(last_cyc[0] - last_accept_cyc), 64'd12);
    for (int i = 0; i < 16; i++) begin
      expect_beat(64'(300 + i), i == 15);
      send(64'(300 + i), 1'b0);
    end
    drain();
    check("t3_pkts", 64'(pkt_count), 64'(exp_pkts));
    cfg_timeout = 16'd0;

    // Backpressure: ready held low, then toggling.
    cfg_frame_len = 16'd3;
    tready_mode = 1;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          expect_beat(64'(400 + i), (i % 3) == 2);
          send(64'(400 + i), 1'b0);
        end
      end
      begin
        repeat (10) @(negedge clk);
        check("t4_in_ready_low", 64'(in_ready), 64'd0);
        repeat (10) @(posedge clk);
        tready_mode = 2;
      end
    join
    tready_mode = 0;
    drain();
    check("t4_pkts", 64'(pkt_count), 64'(exp_pkts));

    // Flush with nothing pending is ignored; flush with a word makes it last.
    cfg_frame_len = 16'd0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_empty_flush_pkts", 64'(pkt_count), 64'(exp_pkts));
    check("t5_empty_flush_busy", 64'(busy), 64'd0);
    expect_beat(64'd500, 1'b0);
    send(64'd500, 1'b0);
    expect_beat(64'd501, 1'b1);
    send(64'd501, 1'b1);
    drain();
    check("t5_pkts", 64'(pkt_count), 64'(exp_pkts));

    // Mid-packet reset discards the partial packet and restarts framing.
    cfg_frame_len = 16'd4;
    expect_beat(64'd600, 1'b0);
    send(64'd600, 1'b0);
    send(64'd601, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_rst_pkts", 64'(pkt_count), 64'd0);
    check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    exp_pkts = 0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_beat(64'(610 + i), i == 3);
      send(64'(610 + i), 1'b0);
    end
    drain();
    check("t6_pkts", 64'(pkt_count), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
